matrix_alu_seq: RTL and testbench

Parametrised N x N matrix ALU, successor to the fixed 3x3 ALUMatrixTop. Holds operand matrices A and B and result C in internal registers, loaded and read element-by-element through the same flat row-major index scheme. Supports transpose, add, subtract, Hadamard product and a sequential matrix multiply. Runs under an explicit start/busy/done handshake, replacing select-code-triggered operations.

---
 rtl/matrix_alu_pkg.sv | 32 +++
 rtl/matrix_alu_mac.sv | 23 ++
 rtl/matrix_alu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_matrix_alu_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_alu_pkg.sv
// ---------------------------------------------------------------------------
// matrix_alu_pkg
// Shared definitions for the N x N matrix ALU:
//   - operation codes accepted on the op port (OP_TRANSPOSE .. OP_MUL)
//   - sequencer state encoding (IDLE / RUN / FIN)
//   - helper functions: element-index width and op-code legality
// ---------------------------------------------------------------------------
package matrix_alu_pkg;

  localparam logic [2:0] OP_TRANSPOSE = 3'd0;
  localparam logic [2:0] OP_ADD       = 3'd1;
  localparam logic [2:0] OP_SUB       = 3'd2;
  localparam logic [2:0] OP_HADAMARD  = 3'd3;
  localparam logic [2:0] OP_MUL       = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Width of a flat row-major index covering n*n elements.
  function automatic int idx_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  // Codes above OP_MUL are reserved and reported through err.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/matrix_alu_mac.sv
// ---------------------------------------------------------------------------
// matrix_alu_mac
// Combinational multiply-accumulate: y_o = (a_i * b_i + acc_i) mod 2^DW.
// Shared by the Hadamard product (acc_i = 0) and the matrix multiply.
// Ports:
//   a_i, b_i  DW-bit unsigned factors
//   acc_i     DW-bit unsigned addend
//   y_o       DW-bit truncated result
// ---------------------------------------------------------------------------
module matrix_alu_mac #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] acc_i,
  output logic [DW-1:0] y_o
);

  // Every operand is DW bits wide, so the product is evaluated in a DW-bit
  // context and keeps only its low DW bits before the wrapping add.
  assign y_o = a_i * b_i + acc_i;

endmodule

// File: rtl/matrix_alu_seq.sv
// ---------------------------------------------------------------------------
// matrix_alu_seq
// Parametrised N x N matrix ALU with internal operand (A, B) and result (C)
// storage. Operands are loaded element-by-element, an operation is launched
// with start, and C is read back element-by-element.
// Ops: transpose, add, subtract, Hadamard product, sequential multiply.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   wr_en/wr_sel        operand write strobe, 0 = A, 1 = B
//   wr_idx/wr_data      row-major element index and value
//   op/start            operation code, sampled when start is seen in IDLE
//   busy/done/err       running flag, one-cycle completion pulse, illegal op
//   rd_idx/rd_data      row-major index into C, registered read data
// ---------------------------------------------------------------------------
module matrix_alu_seq
  import matrix_alu_pkg::*;
#(
  parameter  int N     = 3,
  parameter  int DW    = 32,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_data,
  input  logic [2:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DW-1:0]    rd_data
);

  localparam int            NN   = N * N;
  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Operand and result storage.
  logic [DW-1:0] a_q [NN];
  logic [DW-1:0] b_q [NN];
  logic [DW-1:0] c_q [NN];

  // Sequencer state.
  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic          err_q, err_d;
  logic [CW-1:0] i_q, i_d;     // result row
  logic [CW-1:0] j_q, j_d;     // result column
  logic [CW-1:0] k_q, k_d;     // inner-product step (multiply only)
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] rd_data_q;

  logic             is_mul;
  logic             k_last;
  logic             c_we;
  logic [DW-1:0]    result;
  logic [DW-1:0]    mac_a, mac_b, mac_acc, mac_y;
  logic [IDX_W-1:0] ij_idx, ji_idx, ik_idx, kj_idx;

  assign ij_idx = IDX_W'(int'(i_q) * N + int'(j_q));
  assign ji_idx = IDX_W'(int'(j_q) * N + int'(i_q));
  assign ik_idx = IDX_W'(int'(i_q) * N + int'(k_q));
  assign kj_idx = IDX_W'(int'(k_q) * N + int'(j_q));

  assign is_mul = (op_q == OP_MUL);
  // Element-wise ops produce one element per cycle; the multiply only
  // completes an element on the last step of its inner product.
  assign k_last = !is_mul || (k_q == LAST);

  // The accumulator restarts at the first step of every inner product and is
  // unused (zero) for the Hadamard product.
  assign mac_a   = a_q[is_mul ? ik_idx : ij_idx];
  assign mac_b   = b_q[is_mul ? kj_idx : ij_idx];
  assign mac_acc = (is_mul && (k_q != '0)) ? acc_q : '0;

  matrix_alu_mac #(.DW(DW)) u_mac (
    .a_i   (mac_a),
    .b_i   (mac_b),
    .acc_i (mac_acc),
    .y_o   (mac_y)
  );

  // Value written into C[i][j] when c_we is set.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    result = mac_y;
    case (op_q)
      OP_TRANSPOSE: result = a_q[ji_idx];
      OP_ADD:       result = a_q[ij_idx] + b_q[ij_idx];
      OP_SUB:       result = a_q[ij_idx] - b_q[ij_idx];
      default:      result = mac_y;
    endcase
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    c_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = op;
          i_d  = '0;
          j_d  = '0;
          k_d  = '0;
          if (op_legal(op)) begin
            err_d   = 1'b0;
            state_d = ST_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_RUN: begin
        acc_d = mac_y;
        if (k_last) begin
          c_we = 1'b1;
          k_d  = '0;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) state_d = ST_FIN;
            else             i_d     = i_q + CW'(1);
          end else begin
            j_d = j_q + CW'(1);
          end
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      err_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  // Operand writes are blocked while running so an op sees frozen inputs;
  // writes with an index past the last element are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the arrays are reset because their all-zero contents after
      // reset are visible through rd_data; storage without that obligation
      // would be left unreset.
      for (int n = 0; n < NN; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      if (wr_en && (state_q != ST_RUN) && (int'(wr_idx) < NN)) begin
        if (wr_sel) b_q[wr_idx] <= wr_data;
        else        a_q[wr_idx] <= wr_data;
      end
      if (c_we) c_q[ij_idx] <= result;
    end
  end

  // Registered read port; out-of-range indices read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= (int'(rd_idx) < NN) ? c_q[rd_idx] : '0;
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_FIN);
  assign err     = err_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_matrix_alu_seq
// Directed bench for matrix_alu_seq (N=3, DW=32). A reference model computes
// the expected C when an op is launched and pushes it into a queue; reads of
// C pop and compare. Latency, busy length, done and err are checked per op.
// ---------------------------------------------------------------------------
module tb_matrix_alu_seq;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int NN = N * N;
  localparam int IW = 4;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          wr_en   = 1'b0;
  logic          wr_sel  = 1'b0;
  logic [IW-1:0] wr_idx  = '0;
  logic [DW-1:0] wr_data = '0;
  logic [2:0]    opr     = '0;
  logic          start   = 1'b0;
  logic          busy, done, err;
  logic [IW-1:0] rd_idx  = '0;
  logic [DW-1:0] rd_data;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] a_m [NN];
  logic [DW-1:0] b_m [NN];
  logic [DW-1:0] c_m [NN];
  logic [DW-1:0] exp_q [$];

  matrix_alu_seq #(.N(N), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .op      (opr),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_el(input logic sel, input int idx, input logic [DW-1:0] val);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_idx  = IW'(idx);
    wr_data = val;
    tick();
    wr_en = 1'b0;
    if (idx < NN) begin
      if (sel) b_m[idx] = val;
      else     a_m[idx] = val;
    end
  endtask

  // Loads base + (ramp ? index : 0) into every element of A or B.
  task automatic load(input logic sel, input logic ramp, input logic [DW-1:0] base);
    for (int i = 0; i < NN; i++)
      write_el(sel, i, base + (ramp ? DW'(i) : '0));
  endtask

  // Reference result; illegal codes leave C untouched.
  function automatic void model(input logic [2:0] o);
    logic [DW-1:0] acc;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (o)
          3'd0: c_m[r*N+c] = a_m[c*N+r];
          3'd1: c_m[r*N+c] = a_m[r*N+c] + b_m[r*N+c];
          3'd2: c_m[r*N+c] = a_m[r*N+c] - b_m[r*N+c];
          3'd3: c_m[r*N+c] = a_m[r*N+c] * b_m[r*N+c];
          3'd4: begin
            acc = '0;
            for (int k = 0; k < N; k++) acc = acc + a_m[r*N+k] * b_m[k*N+c];
            c_m[r*N+c] = acc;
          end
          default: ;
        endcase
      end
    end
    for (int i = 0; i < NN; i++) exp_q.push_back(c_m[i]);
  endfunction

  task automatic read_c(input string tag);
    logic [DW-1:0] exp;
    for (int i = 0; i < NN; i++) begin
      rd_idx = IW'(i);
      tick();
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check($sformatf("%s[%0d]", tag, i), rd_data, exp);
    end
  endtask

  // Launches an op and waits (bounded) for done. With inject set, a second
  // start and an A write are driven while busy; both must be ignored.
  task automatic run_op(input string tag, input logic [2:0] opc, input logic inject);
    int   cycles;
    int   busy_cnt;
    int   exp_cyc;
    logic exp_err;
    exp_err = (opc > 3'd4);
    exp_cyc = exp_err ? 1 : (opc == 3'd4) ? N*N*N + 1 : N*N + 1;
    opr   = opc;
    start = 1'b1;
    model(opc);
    cycles   = 0;
    busy_cnt = 0;
    do begin
      tick();
      cycles++;
      if (cycles == 1) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (inject && cycles == 3) begin
        start   = 1'b1;
        opr     = 3'd2;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_idx  = '0;
        wr_data = 32'd999;
      end
      if (inject && cycles == 5) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (busy) busy_cnt++;
    end while (!done && cycles < 2000);
    check({tag, "_latency"}, 32'(cycles), 32'(exp_cyc));
    check({tag, "_busy_len"}, 32'(busy_cnt), 32'(exp_cyc - 1));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'(0));
    check({tag, "_err_held"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    for (int i = 0; i < NN; i++) begin
      a_m[i] = '0;
      b_m[i] = '0;
      c_m[i] = '0;
    end

    // Reset state.
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_rd", rd_data, 32'(0));
    reset = 1'b1;
    tick();

    // Transpose of a 0..8 ramp.
    load(1'b0, 1'b1, '0);
    run_op("transpose", 3'd0, 1'b0);
    read_c("transpose");

    // Add and subtract of equal ramps.
    load(1'b1, 1'b1, '0);
    run_op("add", 3'd1, 1'b0);
    read_c("add");
    run_op("sub", 3'd2, 1'b0);
    read_c("sub");

    // Matrix multiply of the ramp by itself.
    run_op("mul", 3'd4, 1'b0);
    read_c("mul");

    // Wrap-around: 0 - 1 and 0x10000 * 0x10000.
    load(1'b0, 1'b0, '0);
    load(1'b1, 1'b0, 32'd1);
    run_op("sub_wrap", 3'd2, 1'b0);
    read_c("sub_wrap");
    load(1'b0, 1'b0, 32'h10000);
    load(1'b1, 1'b0, 32'h10000);
    run_op("had_wrap", 3'd3, 1'b0);
    read_c("had_wrap");

    // Illegal op leaves C alone; the next legal start clears err.
    run_op("illegal", 3'd7, 1'b0);
    read_c("illegal");
    run_op("add_after_err", 3'd1, 1'b0);
    read_c("add_after_err");

    // Out-of-range writes dropped, out-of-range reads return zero.
    write_el(1'b0, 9, 32'hDEAD);
    write_el(1'b1, 15, 32'hBEEF);
    rd_idx = IW'(9);
    tick();
    check("rd_oob_9", rd_data, 32'(0));
    rd_idx = IW'(15);
    tick();
    check("rd_oob_15", rd_data, 32'(0));

    // start and write while busy are ignored; A is then read back via transpose.
    load(1'b0, 1'b1, '0);
    load(1'b1, 1'b1, '0);
    run_op("add_busy", 3'd1, 1'b1);
    read_c("add_busy");
    run_op("a_frozen", 3'd0, 1'b0);
    read_c("a_frozen");

    // Write and start in the same idle cycle: the op uses the new value.
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_idx  = IW'(4);
    wr_data = 32'd100;
    a_m[4]  = 32'd100;
    run_op("wr_start", 3'd1, 1'b0);
    read_c("wr_start");

    // Reset in the middle of a multiply.
    load(1'b0, 1'b1, '0);
    load(1'b1, 1'b1, '0);
    opr   = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("mid_busy", 32'(busy), 32'(1));
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_rd", rd_data, 32'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_no_done%0d", i), 32'(done), 32'(0));
    end
    reset = 1'b1;
    for (int i = 0; i < NN; i++) begin
      a_m[i] = '0;
      b_m[i] = '0;
      c_m[i] = '0;
    end
    exp_q.delete();
    for (int i = 0; i < NN; i++) exp_q.push_back(c_m[i]);
    read_c("after_rst");
    run_op("a_cleared", 3'd0, 1'b0);
    read_c("a_cleared");

    // Fresh multiply after reset.
    load(1'b0, 1'b1, '0);
    load(1'b1, 1'b1, '0);
    run_op("mul2", 3'd4, 1'b0);
    read_c("mul2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
